mem_stage: RTL

//  - MIPS pipeline MEM stage: takes the registered EXE/MEM bundle and performs the data-memory load/store.
//  - Contains a word-addressed data RAM and a wait-state FSM that models memory latency.
//    The FSM raises a stall toward the EXE/MEM register.
//  - Drives the registered MEM/WB bundle consumed by the write-back mux.

---
 rtl/mem_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// MIPS MEM stage: word-addressed data RAM behind a wait-state FSM, registered
// MEM/WB bundle. Optional feature macro: MISALIGN_TRAP_EN (misaligned trap).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteIn,
  input  logic [1:0]  WB_In,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] writeDataIn,
  input  logic [4:0]  destIn,
  input  logic [31:0] PC_In,
  output logic        stall,
  output logic [1:0]  WB_Out,
  output logic [31:0] readDataOut,
  output logic [31:0] ALUResOut,
  output logic [4:0]  destOut,
  output logic [31:0] PC_Out,
  output logic        misalignOut
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    wb_q;
  logic [31:0]   rdata_q, alures_q, pc_q;
  logic [4:0]    dest_q;
  logic          mis_q;
  logic [31:0]   ram_q [MEM_DEPTH];

  logic          w_access;
  logic          w_mis;
  logic          w_complete;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr_bits;

  assign w_access = memWriteIn | WB_In[0];
  assign w_idx    = ALUResIn[AW+1:2];
  assign w_unused_addr_bits = ^{ALUResIn[31:AW+2], ALUResIn[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign w_mis = w_access & (ALUResIn[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    w_complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Misaligned traps bypass the wait states entirely.
        if (w_access && !w_mis && (MEM_LATENCY > 0)) begin
          stall   = 1'b1;
          cnt_d   = 3'(MEM_LATENCY - 1);
          state_d = ST_BUSY;
        end else begin
          w_complete = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          w_complete = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM is not reset; rst gates the write so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && memWriteIn && !w_mis) begin
      ram_q[w_idx] <= writeDataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_complete) begin
      wb_q     <= 2'b00;
      rdata_q  <= 32'd0;
      alures_q <= 32'd0;
      dest_q   <= 5'd0;
      pc_q     <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      wb_q     <= w_mis ? 2'b00 : WB_In;
      rdata_q  <= (WB_In[0] && !w_mis) ? ram_q[w_idx] : 32'd0;
      alures_q <= ALUResIn;
      dest_q   <= destIn;
      pc_q     <= PC_In;
      mis_q    <= w_mis;
    end
  end

  assign WB_Out      = wb_q;
  assign readDataOut = rdata_q;
  assign ALUResOut   = alures_q;
  assign destOut     = dest_q;
  assign PC_Out      = pc_q;
  assign misalignOut = mis_q;

endmodule

`default_nettype wire
